seg_scan_display: RTL and testbench

Parametrised, time-multiplexed multi-digit seven-segment driver for board display output. It decodes each 4-bit hex nibble into a segment pattern and scans the digits one at a time. It also provides per-digit enable, decimal points, optional leading-zero suppression, an anti-ghosting blank gap, and tear-free frame-synchronous data update. It sits between datapath debug/result registers and the board anode/segment pins.

---
 rtl/seg_scan_display_pkg.sv | 46 ++++
 rtl/seg_scan_display_if.sv | 37 +++
 rtl/seg_scan_display_hex7seg_dec.sv | 13 +
 rtl/seg_scan_display.sv | 155 +++++++++++++++
 tb/tb_seg_scan_display.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_display_pkg.sv
// seg_pkg: shared constants and helpers for the seven-segment scan driver.
//   SEG_BLANK   : active-low all-segments-off pattern {a,b,c,d,e,f,g}
//   ANODE_OFF   : active-low all-anodes-off pattern (widest legal display)
//   HEX_GLYPH   : 16-entry hex nibble to active-low segment table
//   anode_sel   : active-low one-hot-low anode word for a digit index
//   params_ok   : elaboration-time legality check of the scan parameters
package seg_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  // Bit 6 is segment a, bit 0 is segment g; a 0 lights the segment.
  localparam logic [6:0] HEX_GLYPH [0:15] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  function automatic logic [MAX_DIGITS-1:0] anode_sel(input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] one_hot;
    one_hot = {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
    return ~one_hot;
  endfunction

  function automatic bit params_ok(input int num_digits, input int scan_div,
                                   input int blank_cyc);
    return (num_digits >= 1) && (num_digits <= MAX_DIGITS) &&
           (scan_div >= 2) && (blank_cyc >= 0) && (blank_cyc < scan_div);
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: groups the datapath-facing inputs and the board-facing
// display pins of the scan driver.
//   data[4*NUM_DIGITS]  : hex nibbles, digit 0 in bits [3:0] (rightmost)
//   load                : capture data/dp/digit_en into staging
//   digit_en[NUM_DIGITS]: per-digit enable (0 = dark)
//   dp[NUM_DIGITS]      : per-digit decimal point (1 = lit)
//   lz_en               : leading-zero suppression, used live
//   an[NUM_DIGITS]      : active-low anodes
//   seg[7]              : active-low segments {a..g}
//   dp_n                : active-low decimal point
//   frame_start         : one-cycle pulse at the start of slot 0
// master = the register/datapath side, slave = the driver.
interface seg_scan_display_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] data;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    lz_en;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp_n;
  logic                    frame_start;

  modport master (
    output data, load, digit_en, dp, lz_en,
    input  an, seg, dp_n, frame_start
  );

  modport slave (
    input  data, load, digit_en, dp, lz_en,
    output an, seg, dp_n, frame_start
  );

endinterface

// File: rtl/seg_scan_display_hex7seg_dec.sv
// hex7seg_dec: combinational hex nibble to seven-segment decoder.
//   nibble[4] : hex value 0..F
//   seg[7]    : active-low segments {a,b,c,d,e,f,g}, bit 6 = a
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed multi-digit seven-segment driver.
// Scans NUM_DIGITS digits, SCAN_DIV cycles per digit slot, with the first
// BLANK_CYC cycles of every slot dark to avoid ghosting. New values are
// staged on load and committed to the displayed copy only on the frame-end
// edge so a frame never shows a mix of old and new data.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : seg_scan_display_if slave (inputs data/load/digit_en/dp/
//                lz_en, registered outputs an/seg/dp_n/frame_start)
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_scan_display_if.slave   bus
);

  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int NIB_W  = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = ANODE_OFF[NUM_DIGITS-1:0];

  if (!params_ok(NUM_DIGITS, SCAN_DIV, BLANK_CYC)) begin : g_param_check
    $error("seg_scan_display: illegal NUM_DIGITS/SCAN_DIV/BLANK_CYC");
  end

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  slot_end;
  logic                  frame_end;

  logic [NIB_W-1:0]      stg_data;
  logic [NUM_DIGITS-1:0] stg_dp;
  logic [NUM_DIGITS-1:0] stg_en;
  logic [NIB_W-1:0]      disp_data;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] disp_en;

  logic [NUM_DIGITS-1:0] supp;
  logic                  zero_run;

  logic [3:0]            nib_p0;
  logic [6:0]            glyph_p0;
  logic [MAX_DIGITS-1:0] sel_p0;
  logic                  active_p0;
  logic [NUM_DIGITS-1:0] an_p0;
  logic [6:0]            seg_p0;
  logic                  dpn_p0;
  logic                  fs_p0;

  logic [NUM_DIGITS-1:0] an_p1;
  logic [6:0]            seg_p1;
  logic                  dpn_p1;
  logic                  fs_p1;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load coinciding with the frame-end edge bypasses staging so the new
  // values are visible from the very next slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_data  <= '0;
      stg_dp    <= '0;
      stg_en    <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
      disp_en   <= '0;
    end else begin
      if (bus.load) begin
        stg_data <= bus.data;
        stg_dp   <= bus.dp;
        stg_en   <= bus.digit_en;
      end
      if (frame_end) begin
        disp_data <= bus.load ? bus.data     : stg_data;
        disp_dp   <= bus.load ? bus.dp       : stg_dp;
        disp_en   <= bus.load ? bus.digit_en : stg_en;
      end
    end
  end

  // Walk from the most significant digit down; a digit is a leading zero
  // while every digit above it (and itself) is zero. Digit 0 always shows.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (disp_data[4*i +: 4] == 4'h0);
      if (i > 0) supp[i] = zero_run;
    end
  end

  hex7seg_dec u_dec (
    .nibble (nib_p0),
    .seg    (glyph_p0)
  );

  // Stage p0: decode the current (idx, cnt, disp) state.
  always_comb begin
    nib_p0    = disp_data[{idx, 2'b00} +: 4];
    sel_p0    = anode_sel(3'(idx));
    active_p0 = (cnt >= BLANK_END) && disp_en[idx] &&
                !(bus.lz_en && supp[idx]);
    an_p0     = AN_OFF;
    seg_p0    = SEG_BLANK;
    dpn_p0    = 1'b1;
    fs_p0     = (cnt == '0) && (idx == '0);
    if (active_p0) begin
      an_p0  = sel_p0[NUM_DIGITS-1:0];
      seg_p0 = glyph_p0;
      dpn_p0 = ~disp_dp[idx];
    end
  end

  // Stage p1: registered board outputs, one cycle behind the scan state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1  <= AN_OFF;
      seg_p1 <= SEG_BLANK;
      dpn_p1 <= 1'b1;
      fs_p1  <= 1'b0;
    end else begin
      an_p1  <= an_p0;
      seg_p1 <= seg_p0;
      dpn_p1 <= dpn_p0;
      fs_p1  <= fs_p0;
    end
  end

  assign bus.an          = an_p1;
  assign bus.seg         = seg_p1;
  assign bus.dp_n        = dpn_p1;
  assign bus.frame_start = fs_p1;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display with NUM_DIGITS=4, SCAN_DIV=4,
// BLANK_CYC=1. The stimulus thread pushes one expected output word per
// clock cycle; the monitor pops one word at every falling edge and compares.
module tb_seg_scan_display;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BC = 1;

  localparam logic [6:0] BLK = 7'b1111111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seg_scan_display_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_display #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       fs;
    string      tag;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  cur_e;
  string cur_tag = "init";
  int    tag_n   = 0;
  int    checks  = 0;
  int    errors  = 0;
  logic  end_req = 1'b0;
  logic  end_ack = 1'b0;

  task automatic push_item(input logic [3:0] an, input logic [6:0] seg,
                           input logic dpn, input logic fs);
    exp_t e;
    e.an   = an;
    e.seg  = seg;
    e.dp_n = dpn;
    e.fs   = fs;
    e.tag  = $sformatf("%s#%0d", cur_tag, tag_n);
    tag_n++;
    exp_q.push_back(e);
  endtask

  // One slot: one blank cycle, then three lit cycles.
  task automatic push_slot(input logic [3:0] an, input logic [6:0] seg,
                           input logic dpn, input logic fs);
    push_item(4'hF, BLK, 1'b1, fs);
    for (int i = 0; i < 3; i++) push_item(an, seg, dpn, 1'b0);
  endtask

  task automatic push_dark_frames(input int n);
    for (int f = 0; f < n; f++) begin
      push_slot(4'hF, BLK, 1'b1, 1'b1);
      for (int s = 1; s < 4; s++) push_slot(4'hF, BLK, 1'b1, 1'b0);
    end
  endtask

  task automatic push_frame_all(input logic [6:0] g);
    push_slot(4'b1110, g, 1'b1, 1'b1);
    push_slot(4'b1101, g, 1'b1, 1'b0);
    push_slot(4'b1011, g, 1'b1, 1'b0);
    push_slot(4'b0111, g, 1'b1, 1'b0);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Asserts reset now, expects blank outputs at the next falling edge,
  // releases after a rising edge and returns just after the first rising
  // edge following release (output cycle k=1).
  task automatic reset_dut();
    rst_n = 1'b0;
    tag_n = 0;
    push_item(4'hF, BLK, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tag_n = 1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] en,
                         input logic [3:0] p);
    bus.data     = d;
    bus.digit_en = en;
    bus.dp       = p;
    bus.load     = 1'b1;
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        cur_e = exp_q.pop_front();
        checks++;
        if (bus.an !== cur_e.an || bus.seg !== cur_e.seg ||
            bus.dp_n !== cur_e.dp_n || bus.frame_start !== cur_e.fs) begin
          errors++;
          $display("FAIL %s: got an=%b seg=%b dp_n=%b fs=%b, want an=%b seg=%b dp_n=%b fs=%b",
                   cur_e.tag, bus.an, bus.seg, bus.dp_n, bus.frame_start,
                   cur_e.an, cur_e.seg, cur_e.dp_n, cur_e.fs);
        end
      end
      if (end_req && !end_ack) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL leftover: %0d expected cycles unchecked, want 0", exp_q.size());
        end
        end_ack = 1'b1;
      end
    end
  end

  initial begin
    bus.data     = '0;
    bus.load     = 1'b0;
    bus.digit_en = '0;
    bus.dp       = '0;
    bus.lz_en    = 1'b0;

    // S1: reset state, then 12AF shown from frame 1 (F, A, 2, 1).
    cur_tag = "s1_reset";
    reset_dut();
    cur_tag = "s1_scan";
    do_load(16'h12AF, 4'hF, 4'h0);
    push_dark_frames(1);
    push_slot(4'b1110, 7'b0111000, 1'b1, 1'b1);
    push_slot(4'b1101, 7'b0001000, 1'b1, 1'b0);
    push_slot(4'b1011, 7'b0010010, 1'b1, 1'b0);
    push_slot(4'b0111, 7'b1001111, 1'b1, 1'b0);
    run(1);
    bus.load = 1'b0;
    run(30);

    // S2: reset asserted mid-slot while digit 1 is lit; must blank at once.
    cur_tag = "s2_pre";
    push_slot(4'b1110, 7'b0111000, 1'b1, 1'b1);
    push_item(4'hF, BLK, 1'b1, 1'b0);
    push_item(4'b1101, 7'b0001000, 1'b1, 1'b0);
    run(7);
    #1;
    cur_tag = "s2_async_reset";
    reset_dut();
    cur_tag = "s2_dark";
    push_dark_frames(2);
    run(31);

    // S3: leading-zero suppression on 0050, then lz_en dropped live.
    cur_tag = "s3_reset";
    reset_dut();
    cur_tag = "s3_lz";
    bus.lz_en = 1'b1;
    do_load(16'h0050, 4'hF, 4'h0);
    push_dark_frames(1);
    push_slot(4'b1110, 7'b0000001, 1'b1, 1'b1);
    push_slot(4'b1101, 7'b0100100, 1'b1, 1'b0);
    push_slot(4'hF, BLK, 1'b1, 1'b0);
    push_slot(4'hF, BLK, 1'b1, 1'b0);
    push_slot(4'b1110, 7'b0000001, 1'b1, 1'b1);
    push_slot(4'b1101, 7'b0100100, 1'b1, 1'b0);
    push_slot(4'b1011, 7'b0000001, 1'b1, 1'b0);
    push_slot(4'b0111, 7'b0000001, 1'b1, 1'b0);
    run(1);
    bus.load = 1'b0;
    run(30);
    bus.lz_en = 1'b0;
    run(16);

    // S4: load mid-frame waits for the frame boundary; a load on the
    // frame-end edge is shown at once and overrides an earlier load.
    cur_tag = "s4_tearfree";
    push_slot(4'b1110, 7'b0000001, 1'b1, 1'b1);
    push_slot(4'b1101, 7'b0100100, 1'b1, 1'b0);
    push_slot(4'b1011, 7'b0000001, 1'b1, 1'b0);
    push_slot(4'b0111, 7'b0000001, 1'b1, 1'b0);
    push_frame_all(7'b1001111);
    push_frame_all(7'b0010010);
    run(7);
    do_load(16'h1111, 4'hF, 4'h0);
    run(1);
    bus.load = 1'b0;
    run(13);
    do_load(16'h3333, 4'hF, 4'h0);
    run(1);
    bus.load = 1'b0;
    run(9);
    do_load(16'h2222, 4'hF, 4'h0);
    run(1);
    bus.load = 1'b0;
    run(16);

    // S5: digit enables 1010 with decimal point on digit 1 only.
    cur_tag = "s5_en_dp";
    do_load(16'h1234, 4'b1010, 4'b0010);
    push_frame_all(7'b0010010);
    for (int f = 0; f < 2; f++) begin
      push_slot(4'hF, BLK, 1'b1, 1'b1);
      push_slot(4'b1101, 7'b0000110, 1'b0, 1'b0);
      push_slot(4'hF, BLK, 1'b1, 1'b0);
      push_slot(4'b0111, 7'b1001111, 1'b1, 1'b0);
    end
    run(1);
    bus.load = 1'b0;
    run(47);

    end_req = 1'b1;
    for (int i = 0; i < 5 && !end_ack; i++) @(posedge clk);
    if (!end_ack) begin
      $display("FAIL end_sync: monitor ack=%b, want 1", end_ack);
      $fatal(1, "monitor did not acknowledge end of run");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
